// File: rtl/control_unit.sv
// Control sequencer for the single-bus datapath: one T-state per clock, fetch in T0-T2,
// then per-opcode execute steps in T3-T7. Strobes decode the current state and the live IR.
module control_unit #(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned IR_W     = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [IR_W-1:0]     IR,
  input  logic                CON_FF,
  input  logic                Stop,
  output logic                PCout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                InPortout,
  output logic                Cout,
  output logic                BAout,
  output logic                Rout,
  output logic                PCin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                MARin,
  output logic                MDRin,
  output logic                HIin,
  output logic                LOin,
  output logic                Rin,
  output logic                CONin,
  output logic                OutPortin,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                IncPC,
  output logic                Read,
  output logic                Write,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                Run
);

  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_ROL  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(16);
  localparam logic [OPCODE_W-1:0] OP_NEG  = OPCODE_W'(17);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(18);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(19);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(20);
  localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(22);
  localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(23);
  localparam logic [OPCODE_W-1:0] OP_MFHI = OPCODE_W'(24);
  localparam logic [OPCODE_W-1:0] OP_MFLO = OPCODE_W'(25);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(27);

  typedef enum logic [3:0] {
    RST  = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    T7   = 4'd8,
    HALT = 4'd9
  } state_e;

  state_e              state_q, state_d;
  logic                last_step;
  logic [OPCODE_W-1:0] op;
  logic                is_mem, is_rtype, is_imm, is_md, is_unary;
  logic                unused_ir;

  assign op        = IR[IR_W-1 -: OPCODE_W];
  assign unused_ir = ^IR[IR_W-OPCODE_W-1:0];

  assign is_mem   = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  assign is_rtype = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_imm   = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_md    = (op == OP_MUL) || (op == OP_DIV);
  assign is_unary = (op == OP_NEG) || (op == OP_NOT);

  // Strobe decode, end-of-instruction detection and next state.
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; Rin = 1'b0; CONin = 1'b0; OutPortin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op    = '0;
    last_step = 1'b0;
    Run       = (state_q != RST) && (state_q != HALT);
    state_d   = state_q;

    unique case (state_q)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_rtype || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
        end else if (is_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (op == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else begin
          last_step = (op != OP_HALT);
          unique case (op)
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      T4: begin
        if (is_mem) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end else if (is_rtype) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1;
          alu_op = (op == OP_ANDI) ? OP_AND : (op == OP_ORI) ? OP_OR : OP_ADD;
        end else if (is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1;
        end else if (is_md) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
        end else if (op == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          last_step = 1'b1;
        end
      end
      T5: begin
        if (op == OP_LD || op == OP_ST) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (op == OP_LDI || is_rtype || is_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1;
        end else if (is_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (op == OP_BR) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end else begin
          last_step = 1'b1;
        end
      end
      T6: begin
        if (op == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_md) begin
          Zhighout = 1'b1; HIin = 1'b1; last_step = 1'b1;
        end else begin
          // Branch target reaches the PC only when the condition flip-flop is set.
          Zlowout   = (op == OP_BR) && CON_FF;
          PCin      = (op == OP_BR) && CON_FF;
          last_step = 1'b1;
        end
      end
      T7: begin
        if (op == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op == OP_ST) begin
          Write = 1'b1;
        end
        last_step = 1'b1;
      end
      default: ;
    endcase

    unique case (state_q)
      RST:     state_d = T0;
      T0:      state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      HALT:    state_d = HALT;
      default: begin
        if (state_q == T3 && op == OP_HALT) begin
          state_d = HALT;
        end else if (last_step) begin
          state_d = Stop ? HALT : T0;
        end else begin
          unique case (state_q)
            T3:      state_d = T4;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = T7;
            default: state_d = T0;
          endcase
        end
      end
    endcase
  end

  // State register; reset forces RST and thereby drops every strobe at once.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction is expanded into its list of expected per-cycle
// strobe sets and compared cycle by cycle against the DUT, with directed and random programs.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0;
  logic        Stop = 1'b0;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, Rin, CONin, OutPortin;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] alu_op;

  control_unit #(.OPCODE_W(5), .IR_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin),
    .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONin(CONin),
    .OutPortin(OutPortin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run)
  );

  always #5 Clock = ~Clock;

  logic [32:0] obs;
  assign obs = {alu_op, Run, Write, Read, IncPC, Grc, Grb, Gra, OutPortin, CONin, Rin,
                LOin, HIin, MDRin, MARin, Zin, Yin, IRin, PCin, Rout, BAout, Cout,
                InPortout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

  localparam logic [26:0] S_PCOUT  = 27'(1) << 0;
  localparam logic [26:0] S_ZHI    = 27'(1) << 1;
  localparam logic [26:0] S_ZLO    = 27'(1) << 2;
  localparam logic [26:0] S_MDROUT = 27'(1) << 3;
  localparam logic [26:0] S_HIOUT  = 27'(1) << 4;
  localparam logic [26:0] S_LOOUT  = 27'(1) << 5;
  localparam logic [26:0] S_INPORT = 27'(1) << 6;
  localparam logic [26:0] S_COUT   = 27'(1) << 7;
  localparam logic [26:0] S_BAOUT  = 27'(1) << 8;
  localparam logic [26:0] S_ROUT   = 27'(1) << 9;
  localparam logic [26:0] S_PCIN   = 27'(1) << 10;
  localparam logic [26:0] S_IRIN   = 27'(1) << 11;
  localparam logic [26:0] S_YIN    = 27'(1) << 12;
  localparam logic [26:0] S_ZIN    = 27'(1) << 13;
  localparam logic [26:0] S_MARIN  = 27'(1) << 14;
  localparam logic [26:0] S_MDRIN  = 27'(1) << 15;
  localparam logic [26:0] S_HIIN   = 27'(1) << 16;
  localparam logic [26:0] S_LOIN   = 27'(1) << 17;
  localparam logic [26:0] S_RIN    = 27'(1) << 18;
  localparam logic [26:0] S_CONIN  = 27'(1) << 19;
  localparam logic [26:0] S_OUTP   = 27'(1) << 20;
  localparam logic [26:0] S_GRA    = 27'(1) << 21;
  localparam logic [26:0] S_GRB    = 27'(1) << 22;
  localparam logic [26:0] S_GRC    = 27'(1) << 23;
  localparam logic [26:0] S_INCPC  = 27'(1) << 24;
  localparam logic [26:0] S_READ   = 27'(1) << 25;
  localparam logic [26:0] S_WRITE  = 27'(1) << 26;
  localparam logic [4:0]  ALU_ADD  = 5'd3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [32:0] mk(input logic [26:0] s, input logic [4:0] alu);
    return {alu, 1'b1, s};
  endfunction

  function automatic logic [32:0] fetch0();
    return mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'd0);
  endfunction

  // Full cycle-by-cycle strobe list of one instruction, fetch included.
  task automatic build(input logic [4:0] op, input logic con);
    exp_q.delete();
    exp_q.push_back(fetch0());
    exp_q.push_back(mk(S_ZLO | S_PCIN | S_READ | S_MDRIN, 5'd0));
    exp_q.push_back(mk(S_MDROUT | S_IRIN, 5'd0));
    if (op <= 5'd2) begin
      exp_q.push_back(mk(S_GRB | S_BAOUT | S_YIN, 5'd0));
      exp_q.push_back(mk(S_COUT | S_ZIN, ALU_ADD));
      if (op == 5'd1) begin
        exp_q.push_back(mk(S_ZLO | S_GRA | S_RIN, 5'd0));
      end else begin
        exp_q.push_back(mk(S_ZLO | S_MARIN, 5'd0));
        if (op == 5'd0) begin
          exp_q.push_back(mk(S_READ | S_MDRIN, 5'd0));
          exp_q.push_back(mk(S_MDROUT | S_GRA | S_RIN, 5'd0));
        end else begin
          exp_q.push_back(mk(S_GRA | S_ROUT | S_MDRIN, 5'd0));
          exp_q.push_back(mk(S_WRITE, 5'd0));
        end
      end
    end else if (op <= 5'd11) begin
      exp_q.push_back(mk(S_GRB | S_ROUT | S_YIN, 5'd0));
      exp_q.push_back(mk(S_GRC | S_ROUT | S_ZIN, op));
      exp_q.push_back(mk(S_ZLO | S_GRA | S_RIN, 5'd0));
    end else if (op <= 5'd14) begin
      exp_q.push_back(mk(S_GRB | S_ROUT | S_YIN, 5'd0));
      exp_q.push_back(mk(S_COUT | S_ZIN, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6));
      exp_q.push_back(mk(S_ZLO | S_GRA | S_RIN, 5'd0));
    end else if (op <= 5'd16) begin
      exp_q.push_back(mk(S_GRA | S_ROUT | S_YIN, 5'd0));
      exp_q.push_back(mk(S_GRB | S_ROUT | S_ZIN, op));
      exp_q.push_back(mk(S_ZLO | S_LOIN, 5'd0));
      exp_q.push_back(mk(S_ZHI | S_HIIN, 5'd0));
    end else if (op <= 5'd18) begin
      exp_q.push_back(mk(S_GRB | S_ROUT | S_ZIN, op));
      exp_q.push_back(mk(S_ZLO | S_GRA | S_RIN, 5'd0));
    end else if (op == 5'd19) begin
      exp_q.push_back(mk(S_GRA | S_ROUT | S_CONIN, 5'd0));
      exp_q.push_back(mk(S_PCOUT | S_YIN, 5'd0));
      exp_q.push_back(mk(S_COUT | S_ZIN, ALU_ADD));
      exp_q.push_back(mk(con ? (S_ZLO | S_PCIN) : 27'd0, 5'd0));
    end else if (op == 5'd20) exp_q.push_back(mk(S_GRA | S_ROUT | S_PCIN, 5'd0));
    else if (op == 5'd22) exp_q.push_back(mk(S_INPORT | S_GRA | S_RIN, 5'd0));
    else if (op == 5'd23) exp_q.push_back(mk(S_GRA | S_ROUT | S_OUTP, 5'd0));
    else if (op == 5'd24) exp_q.push_back(mk(S_HIOUT | S_GRA | S_RIN, 5'd0));
    else if (op == 5'd25) exp_q.push_back(mk(S_LOOUT | S_GRA | S_RIN, 5'd0));
    else exp_q.push_back(mk(27'd0, 5'd0));
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (3) begin
      @(posedge Clock); #1;
      IR = $urandom;
      chk("in_reset", obs, 33'd0);
    end
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("first_t0", obs, fetch0());
  endtask

  task automatic hold_halt();
    repeat (3) begin
      Stop = 1'($urandom); CON_FF = 1'($urandom); IR = $urandom;
      @(posedge Clock); #1;
      chk("halt_hold", obs, 33'd0);
    end
  endtask

  // Expects to be entered 1 ns into T0; leaves 1 ns into the following state.
  task automatic run_instr(input logic [4:0] op, input logic con, input logic stop_last,
                           input int abort_at, output bit halted);
    int last;
    build(op, con);
    last = exp_q.size() - 1;
    halted = 1'b0;
    for (int i = 0; i <= last; i++) begin
      IR     = (i < 3) ? $urandom : {op, 27'($urandom)};
      CON_FF = con;
      Stop   = (i == last) ? stop_last : 1'($urandom);
      #0;
      chk($sformatf("op%0d_t%0d", op, i), obs, exp_q[i]);
      if (i == abort_at) begin
        #2 Reset = 1'b0;
        #1 chk("async_reset", obs, 33'd0);
        halted = 1'b1;
        return;
      end
      @(posedge Clock); #1;
    end
    Stop = 1'b0;
    if (stop_last || op == 5'd27) begin
      halted = 1'b1;
      chk($sformatf("op%0d_halt", op), obs, 33'd0);
    end else begin
      chk($sformatf("op%0d_next_t0", op), obs, fetch0());
    end
  endtask

  initial begin
    bit h;
    logic [4:0] rop;
    do_reset();
    run_instr(5'd1, 1'b0, 1'b0, -1, h);   // ldi R1,0x95(R0)
    chk("ldi_ir_op", {28'd0, 5'(32'h08800095 >> 27)}, 33'd1);
    run_instr(5'd0, 1'b0, 1'b0, -1, h);   // ld
    run_instr(5'd2, 1'b1, 1'b0, -1, h);   // st
    run_instr(5'd19, 1'b0, 1'b0, -1, h);  // br not taken
    run_instr(5'd19, 1'b1, 1'b0, -1, h);  // br taken
    run_instr(5'd15, 1'b0, 1'b0, -1, h);  // mul
    run_instr(5'd13, 1'b0, 1'b0, -1, h);  // andi
    run_instr(5'd3, 1'b0, 1'b1, -1, h);   // add with Stop
    hold_halt();
    do_reset();
    run_instr(5'd27, 1'b0, 1'b0, -1, h);  // halt
    hold_halt();
    do_reset();
    run_instr(5'd0, 1'b0, 1'b0, 6, h);    // reset during ld T6
    do_reset();
    for (int k = 0; k < 80; k++) begin
      rop = 5'($urandom_range(0, 31));
      run_instr(rop, 1'($urandom), ($urandom_range(0, 9) == 0), -1, h);
      if (h) begin
        hold_halt();
        do_reset();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
